// File: rtl/seq_detect_shift.sv
// Serial pattern detector: WIDTH-sample window, masked compare, saturating count.
// Define SEQ_DETECT_DUAL_EN for a second pattern/mask pair and the z_b output.
module seq_detect_shift #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] mask,
  input  logic             overlap,
`ifdef SEQ_DETECT_DUAL_EN
  input  logic [WIDTH-1:0] pattern_b,
  input  logic [WIDTH-1:0] mask_b,
  output logic             z_b,
`endif
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] win_q, win_d, nwin;
  logic [FW-1:0]    fill_q, fill_d, nfill;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_q, z_d;
  logic             hit_a, hit_b, hit;
  logic             zb_q, zb_d;

  always_comb begin
    nwin  = {in, win_q[WIDTH-1:1]};
    nfill = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    hit_a = in_valid && (nfill == FILL_FULL) &&
            (((nwin ^ pattern) & mask) == '0);
`ifdef SEQ_DETECT_DUAL_EN
    hit_b = in_valid && (nfill == FILL_FULL) &&
            (((nwin ^ pattern_b) & mask_b) == '0);
`else
    hit_b = 1'b0;
`endif
    hit = hit_a | hit_b;
  end

  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    z_d    = 1'b0;
    zb_d   = 1'b0;
    if (clr) begin
      win_d  = '1;
      fill_d = '0;
      cnt_d  = '0;
    end else if (in_valid) begin
      win_d  = nwin;
      fill_d = nfill;
      if (hit) begin
        z_d  = 1'b1;
        zb_d = hit_b;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // non-overlap: window kept, but WIDTH fresh samples needed
        if (!overlap) fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q  <= '1;
      fill_q <= '0;
      cnt_q  <= '0;
      z_q    <= 1'b0;
      zb_q   <= 1'b0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      z_q    <= z_d;
      zb_q   <= zb_d;
    end
  end

  assign z         = z_q;
  assign match_cnt = cnt_q;
`ifdef SEQ_DETECT_DUAL_EN
  assign z_b = zb_q;
`else
  logic unused_zb;
  assign unused_zb = zb_q;
`endif

endmodule

// File: tb/tb_seq_detect_shift.sv
// Directed table-driven bench for seq_detect_shift (default and CNT_W=2 builds).
module tb_seq_detect_shift;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic       in_valid;
  logic       in;
  logic [4:0] pattern;
  logic [4:0] mask;
  logic       overlap;
  logic [4:0] pattern_b;
  logic [4:0] mask_b;
  logic       z, z2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
`ifdef SEQ_DETECT_DUAL_EN
  logic       z_b, z_b2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_shift #(.WIDTH(5), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in(in),
    .pattern(pattern), .mask(mask), .overlap(overlap),
`ifdef SEQ_DETECT_DUAL_EN
    .pattern_b(pattern_b), .mask_b(mask_b), .z_b(z_b),
`endif
    .z(z), .match_cnt(cnt)
  );

  seq_detect_shift #(.WIDTH(5), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in(in),
    .pattern(pattern), .mask(mask), .overlap(overlap),
`ifdef SEQ_DETECT_DUAL_EN
    .pattern_b(pattern_b), .mask_b(mask_b), .z_b(z_b2),
`endif
    .z(z2), .match_cnt(cnt2)
  );

  typedef struct {
    logic       c;
    logic       v;
    logic       i;
    logic [4:0] p;
    logic [4:0] m;
    logic       ov;
    logic [4:0] pb;
    logic [4:0] mb;
    logic       ez;
    logic       ezb;
    int         ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic c, input logic v, input logic i,
                     input logic [4:0] p, input logic [4:0] m,
                     input logic ov, input logic ez, input int ecnt);
    vec_t e;
    e.c = c; e.v = v; e.i = i; e.p = p; e.m = m; e.ov = ov;
    e.pb = p; e.mb = m; e.ez = ez; e.ezb = ez; e.ecnt = ecnt;
    tbl.push_back(e);
  endtask

  task automatic add_b(input logic i, input logic [4:0] pb,
                       input logic [4:0] mb, input logic ez,
                       input logic ezb, input int ecnt);
    vec_t e;
    e.c = 1'b0; e.v = 1'b1; e.i = i;
    e.p = 5'b01000; e.m = 5'b11110; e.ov = 1'b1;
    e.pb = pb; e.mb = mb; e.ez = ez; e.ezb = ezb; e.ecnt = ecnt;
    tbl.push_back(e);
  endtask

  task automatic drive(input vec_t e);
    @(negedge clk);
    clr = e.c; in_valid = e.v; in = e.i;
    pattern = e.p; mask = e.m; overlap = e.ov;
    pattern_b = e.pb; mask_b = e.mb;
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic i, input logic ez, input int ecnt,
                        input string name);
    vec_t e;
    e.c = 1'b0; e.v = 1'b1; e.i = i;
    e.p = 5'b01000; e.m = 5'b11110; e.ov = 1'b1;
    e.pb = 5'b01000; e.mb = 5'b11110;
    e.ez = ez; e.ezb = ez; e.ecnt = ecnt;
    drive(e);
    chk({name, "_z"}, int'(z), int'(ez));
    chk({name, "_cnt"}, int'(cnt), ecnt);
  endtask

  initial begin
    logic [4:0] p1, p2, m1, mall;
    logic [6:0] s2;
    logic [4:0] s1;
    int c2exp;
    p1 = 5'b01000; m1 = 5'b11110;
    p2 = 5'b10101; mall = 5'b11111;
    s1 = 5'b10010;
    s2 = 7'b1010101;

    // scenario 1: masked pattern, overlap
    for (int k = 4; k >= 0; k--)
      add(0, 1, s1[k], p1, m1, 1, k == 0, (k == 0) ? 1 : 0);
    add(1, 1, 1, p1, m1, 1, 0, 0);
    // alternating pattern, overlap on
    for (int k = 6; k >= 0; k--)
      add(0, 1, s2[k], p2, mall, 1, (k == 2) || (k == 0),
          (k <= 0) ? 2 : (k <= 2) ? 1 : 0);
    add(1, 0, 0, p2, mall, 1, 0, 0);
    // alternating pattern, overlap off
    for (int k = 6; k >= 0; k--)
      add(0, 1, s2[k], p2, mall, 0, k == 2, (k <= 2) ? 1 : 0);
    add(1, 1, 0, p2, mall, 0, 0, 0);
    // gaps between samples 2 and 3
    add(0, 1, 1, p1, m1, 1, 0, 0);
    add(0, 1, 0, p1, m1, 1, 0, 0);
    for (int k = 0; k < 3; k++)
      add(0, 0, 1, p1, m1, 1, 0, 0);
    add(0, 1, 0, p1, m1, 1, 0, 0);
    add(0, 1, 1, p1, m1, 1, 0, 0);
    add(0, 1, 0, p1, m1, 1, 1, 1);
    add(0, 0, 0, p1, m1, 1, 0, 1);
    add(1, 0, 0, p1, m1, 1, 0, 0);
    // mask zero: every sample from the 5th matches
    for (int k = 1; k <= 10; k++)
      add(0, 1, k[0], p1, 5'b0, 1, k >= 5, (k >= 5) ? k - 4 : 0);
    add(1, 1, 1, p1, 5'b0, 1, 0, 0);
    // fill restarted by clr: four more samples before a hit
    for (int k = 1; k <= 5; k++)
      add(0, 1, 0, p1, 5'b0, 1, k == 5, (k == 5) ? 1 : 0);
`ifdef SEQ_DETECT_DUAL_EN
    add(1, 0, 0, p1, m1, 1, 0, 0);
    for (int k = 4; k >= 0; k--)
      add_b(5'b00010 >> k, 5'b01000, 5'b11111,
            k == 0, k == 0, (k == 0) ? 1 : 0);
    add(1, 0, 0, p1, m1, 1, 0, 0);
    for (int k = 4; k >= 0; k--)
      add_b(s1[k], 5'b01000, 5'b11111,
            k == 0, 1'b0, (k == 0) ? 1 : 0);
`endif
    add(1, 0, 0, p1, m1, 1, 0, 0);

    reset = 1'b0; clr = 1'b0; in_valid = 1'b0; in = 1'b0;
    pattern = '0; mask = '0; overlap = 1'b0;
    pattern_b = '0; mask_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_z", int'(z), 0);
    chk("reset_cnt", int'(cnt), 0);
    chk("reset_cnt2", int'(cnt2), 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[n]) begin
      drive(tbl[n]);
      c2exp = (tbl[n].ecnt > 3) ? 3 : tbl[n].ecnt;
      chk($sformatf("vec%0d_z", n), int'(z), int'(tbl[n].ez));
      chk($sformatf("vec%0d_cnt", n), int'(cnt), tbl[n].ecnt);
      chk($sformatf("vec%0d_z2", n), int'(z2), int'(tbl[n].ez));
      chk($sformatf("vec%0d_cnt2", n), int'(cnt2), c2exp);
`ifdef SEQ_DETECT_DUAL_EN
      chk($sformatf("vec%0d_zb", n), int'(z_b), int'(tbl[n].ezb));
`endif
    end

    // leave a count behind so the mid-stream reset has something to clear
    for (int k = 4; k >= 0; k--)
      sample(s1[k], k == 0, (k == 0) ? 1 : 0, "pre");
    for (int k = 4; k >= 1; k--)
      sample(s1[k], 1'b0, 1, "part");
    #2 reset = 1'b0;
    #1;
    chk("midrst_z", int'(z), 0);
    chk("midrst_cnt", int'(cnt), 0);
    @(negedge clk);
    reset = 1'b1;
    sample(1'b0, 1'b0, 0, "after_rst");
    for (int k = 4; k >= 0; k--)
      sample(s1[k], k == 0, (k == 0) ? 1 : 0, "fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
